fan_speed_ctrl: RTL

//   Consumes the 2-bit operating mode from the air-conditioner mode FSM and drives the fan.

---
 rtl/ac_pkg.sv | 12 +
 rtl/fan_speed_ctrl_if.sv | 14 +
 rtl/fan_speed_ctrl_pwm_gen.sv | 40 ++++
 rtl/fan_speed_ctrl.sv | 62 ++++++
 4 files changed

// File: rtl/ac_pkg.sv
// ac_pkg: mode codes, fan speed levels and per-level duty targets shared by the air-conditioner blocks
package ac_pkg;
  typedef enum logic [1:0] {MODE_IDLE = 2'd0, MODE_AUTO = 2'd1, MODE_MANUAL = 2'd2} mode_t;
  typedef enum logic [1:0] {SPD_OFF = 2'd0, SPD_LOW = 2'd1, SPD_MID = 2'd2, SPD_HIGH = 2'd3} speed_t;
  localparam logic [7:0] DUTY_OFF = 8'd0;
  localparam logic [7:0] DUTY_LOW = 8'd85;
  localparam logic [7:0] DUTY_MID = 8'd170;
  localparam logic [7:0] DUTY_HIGH = 8'd255;
  function automatic logic [7:0] duty_of(speed_t s);
    return s == SPD_HIGH ? DUTY_HIGH : s == SPD_MID ? DUTY_MID : s == SPD_LOW ? DUTY_LOW : DUTY_OFF;
  endfunction
endpackage

// File: rtl/fan_speed_ctrl_if.sv
// fan_speed_ctrl_if: fan controller bus; master drives mode/temp/temp_valid/btn_up/btn_down, slave returns speed/duty/pwm_out/fan_on
interface fan_speed_ctrl_if #(parameter int TEMP_W = 8);
  logic [1:0] mode;
  logic [TEMP_W-1:0] temp;
  logic temp_valid;
  logic btn_up;
  logic btn_down;
  logic [1:0] speed;
  logic [7:0] duty;
  logic pwm_out;
  logic fan_on;
  modport master (output mode, temp, temp_valid, btn_up, btn_down, input speed, duty, pwm_out, fan_on);
  modport slave (input mode, temp, temp_valid, btn_up, btn_down, output speed, duty, pwm_out, fan_on);
endinterface

// File: rtl/fan_speed_ctrl_pwm_gen.sv
// pwm_gen: prescaler + 0..254 frame counter, duty loaded only at frame start (stepped 1 LSB per frame when SOFT_RAMP_EN), ports clk/reset/target in, duty/pwm_out/fan_on out
module pwm_gen #(
  parameter int PRESC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] target,
  output logic [7:0] duty,
  output logic       pwm_out,
  output logic       fan_on
);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  logic [PW-1:0] psc;
  logic [7:0] cnt, load, duty_nxt;
  logic psc_wrap, frame_start;
  always_comb begin
    psc_wrap = psc == PW'(PRESC - 1);
    frame_start = psc == '0 && cnt == '0;
`ifdef SOFT_RAMP_EN
    load = duty < target ? duty + 8'd1 : duty > target ? duty - 8'd1 : duty;
`else
    load = target;
`endif
    duty_nxt = frame_start ? load : duty;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      psc <= '0;
      cnt <= '0;
      duty <= '0;
      pwm_out <= 1'b0;
      fan_on <= 1'b0;
    end else begin
      psc <= psc_wrap ? '0 : psc + PW'(1);
      if (psc_wrap) cnt <= cnt == 8'd254 ? '0 : cnt + 8'd1;
      duty <= duty_nxt;
      pwm_out <= cnt < duty_nxt;
      fan_on <= duty_nxt != '0;
    end
endmodule

// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: mode-driven fan speed FSM (AUTO hysteresis / MANUAL buttons / IDLE off) feeding pwm_gen; ports clk, reset, bus (fan_speed_ctrl_if.slave); SOFT_RAMP_EN enables per-frame duty ramping
module fan_speed_ctrl
  import ac_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int PWM_HZ = 25_000,
  parameter int TEMP_W = 8,
  parameter int T_LOW = 24,
  parameter int T_MID = 27,
  parameter int T_HIGH = 30,
  parameter int HYST = 1
) (
  input logic clk,
  input logic reset,
  fan_speed_ctrl_if.slave bus
);
  localparam int PRESC_RAW = CLK_HZ / (PWM_HZ * 255);
  localparam int PRESC = PRESC_RAW < 1 ? 1 : PRESC_RAW;
  mode_t state, state_nxt;
  speed_t speed_q, speed_nxt, auto_lvl, auto_nxt, man_lvl, man_nxt, up_lvl, hold_lvl, new_auto, man_base, man_step;
  logic [TEMP_W-1:0] t_s;
  function automatic speed_t lvl_at(int t, int off);
    return t >= T_HIGH - off ? SPD_HIGH : t >= T_MID - off ? SPD_MID : t >= T_LOW - off ? SPD_LOW : SPD_OFF;
  endfunction
  // up_lvl: highest threshold met; hold_lvl: highest level whose threshold minus HYST is still met.
  // The new auto level is max(up_lvl, min(current, hold_lvl)), which allows multi-level drops in one sample.
  always_comb begin
    state_nxt = bus.mode == MODE_AUTO ? MODE_AUTO : bus.mode == MODE_MANUAL ? MODE_MANUAL : MODE_IDLE;
    t_s = bus.temp;
    up_lvl = lvl_at(int'(t_s), 0);
    hold_lvl = lvl_at(int'(t_s), HYST);
    new_auto = up_lvl > auto_lvl ? up_lvl : hold_lvl < auto_lvl ? hold_lvl : auto_lvl;
    man_base = state == MODE_AUTO ? auto_lvl : man_lvl;
    man_step = bus.btn_up && !bus.btn_down && man_base != SPD_HIGH ? speed_t'(man_base + 2'd1) :
               bus.btn_down && !bus.btn_up && man_base != SPD_OFF ? speed_t'(man_base - 2'd1) : man_base;
    auto_nxt = state_nxt == MODE_IDLE ? SPD_OFF : state_nxt == MODE_AUTO && bus.temp_valid ? new_auto : auto_lvl;
    man_nxt = state_nxt == MODE_IDLE ? SPD_OFF : state_nxt == MODE_MANUAL ? man_step : man_lvl;
    speed_nxt = state_nxt == MODE_IDLE ? SPD_OFF : state_nxt == MODE_MANUAL ? man_step :
                bus.temp_valid ? new_auto : speed_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= MODE_IDLE;
      speed_q <= SPD_OFF;
      auto_lvl <= SPD_OFF;
      man_lvl <= SPD_OFF;
    end else begin
      state <= state_nxt;
      speed_q <= speed_nxt;
      auto_lvl <= auto_nxt;
      man_lvl <= man_nxt;
    end
  assign bus.speed = speed_q;
  pwm_gen #(.PRESC(PRESC)) u_pwm (
    .clk(clk),
    .reset(reset),
    .target(duty_of(speed_q)),
    .duty(bus.duty),
    .pwm_out(bus.pwm_out),
    .fan_on(bus.fan_on)
  );
endmodule
